ccr_ctrl: RTL and testbench
===========================

// Module: ccr_ctrl
// PURPOSE
//  Condition-code register (CCR) controller for the 5-stage pipeline. Owns the architectural Z/N/C flags.
//  Merges the ALU's per-op flag output, SETC/CLRC, and conditional-jump consumption.
//  Saves/restores flags on interrupt entry/RTI through a shadow stack.
//  Sits beside the execute stage and feeds branch resolution in decode.
// PARAMETERS
//  DEPTH  4  shadow-stack entries (nested interrupt levels)
//  CNT_W  3  width of stack-depth counter; must hold 0..DEPTH
// PORTS
//  clk          in   1      system clock, all state on rising edge
//  rst_n        in   1      asynchronous active-low reset
//  stall        in   1      pipeline freeze; no state changes this cycle
//  ex_valid     in   1      valid instruction in execute this cycle
//  alu_op       in   4      ALU opcode of execute instruction
//  alu_flags    in   3      ALU flag output {C,N,Z} = bits [2:0]
//  setc         in   1      SETC in execute (qualified by ex_valid)
//  clrc         in   1      CLRC in execute (qualified by ex_valid)
//  br_valid     in   1      conditional jump in decode
//  br_cond      in   2      00 JZ, 01 JN, 10 JC, 11 JMP (unconditional)
//  int_save     in   1      interrupt entry: push flags
//  rti_restore  in   1      RTI: pop flags
//  ccr          out  3      registered flags {C,N,Z}
//  br_taken     out  1      combinational branch decision
//  depth        out  CNT_W  entries currently on the shadow stack
//  ovf_err      out  1      sticky: push attempted while full
//  unf_err      out  1      sticky: pop attempted while empty
// BEHAVIOUR
//  Reset (async, rst_n=0): ccr=0, depth=0, ovf_err=0, unf_err=0, stack contents=0.
//   br_taken follows its equation, so it is 0 unless br_valid & br_cond=11.
//  stall=1: ccr, stack, depth and the error bits hold.
//   br_taken is still driven combinationally from nxt (decode re-evaluates).
//  nxt (combinational) is built from ccr, in order:
//   1. ALU update, only when ex_valid:
//      - Z,N take alu_flags for ops 0100..1101 except 0111 (MOV leaves flags untouched).
//      - C takes alu_flags[2] only for INC 0101, ADD 1000, SHL 1100, SHR 1101.
//      - Every other flag keeps its value; ops 0000..0011 change nothing.
//   2. ex_valid & setc -> C=1; ex_valid & clrc -> C=0. If both are asserted, C is unchanged.
//   3. Branch evaluation on the post-step-2 value (forwards the older execute result):
//      - br_taken = br_valid & (JZ:Z | JN:N | JC:C | JMP:1).
//      - A taken JZ/JN/JC clears its tested flag in nxt; JMP clears nothing.
//  Per-cycle update (when not stalled), in priority order:
//   - rti_restore: depth>0 -> ccr<=stack[depth-1], depth-1, and all nxt updates are discarded.
//     depth==0 -> ccr<=nxt, unf_err<=1.
//   - int_save (no restore): depth<DEPTH -> stack[depth]<=nxt, depth+1, ccr<=nxt.
//     depth==DEPTH -> ccr<=nxt, stack unchanged, ovf_err<=1.
//   - int_save & rti_restore together: the restore alone is performed; the save is dropped, with no error.
//   - Otherwise ccr<=nxt.
//  Latency: a flag update is visible on ccr 1 cycle after its input cycle.
//   br_taken sees the same-cycle execute result with 0 latency.
//  Stack is LIFO. depth never wraps: it saturates at 0 and at DEPTH.
//   Error bits clear only on reset.
//  Reset mid-operation: state is lost immediately, with no pending push/pop completion.
// TESTING
//  T1: ADD with alu_flags=3'b101, ex_valid=1 -> next cycle ccr=101.
//      Then MOV (0111) with flags=010 -> ccr stays 101.
//  T2: ccr=000; DEC with flags=001 in the same cycle as br_valid JZ -> br_taken=1 that cycle, next ccr=000.
//      Repeat with JN -> br_taken=0, ccr=001.
//  T3: ccr=000; SHL with C=1 plus setc&clrc -> ccr=100. Then clrc alone -> ccr=000.
//  T4: Push 4x with distinct ccr values 001,010,011,100 -> depth=4.
//      5th int_save -> ovf_err=1, depth=4.
//      4 rti_restore -> ccr=100,011,010,001 in sequence, depth=0.
//      5th rti_restore -> unf_err=1.
//  T5: stall=1 while ex_valid ADD flags=111 and int_save -> ccr, depth unchanged.
//      Deassert stall -> applied next cycle.
//  T6: depth=1 (saved 010), ccr=101, rst_n pulsed low mid-cycle -> ccr=0, depth=0, errors=0 immediately.
//      Then int_save & rti_restore together with an empty stack -> unf_err=1, depth=0.

Source files
------------

// File: rtl/ccr_ctrl_if.sv
// ============================================================================
//  Module   : ccr_ctrl_if
//  Purpose  : Bundle of pipeline-side signals for the condition-code register
//             controller (execute-stage updates, decode branch query, stack).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface ccr_ctrl_if #(
    parameter int CNT_W = 3
);
    logic             stall;
    logic             ex_valid;
    logic [3:0]       alu_op;
    logic [2:0]       alu_flags;
    logic             setc;
    logic             clrc;
    logic             br_valid;
    logic [1:0]       br_cond;
    logic             int_save;
    logic             rti_restore;
    logic [2:0]       ccr;
    logic             br_taken;
    logic [CNT_W-1:0] depth;
    logic             ovf_err;
    logic             unf_err;

    modport master (
        output stall, ex_valid, alu_op, alu_flags, setc, clrc,
               br_valid, br_cond, int_save, rti_restore,
        input  ccr, br_taken, depth, ovf_err, unf_err
    );

    modport slave (
        input  stall, ex_valid, alu_op, alu_flags, setc, clrc,
               br_valid, br_cond, int_save, rti_restore,
        output ccr, br_taken, depth, ovf_err, unf_err
    );
endinterface

`default_nettype wire

// File: rtl/ccr_ctrl.sv
// ============================================================================
//  Module   : ccr_ctrl
//  Purpose  : Owns the Z/N/C condition codes; merges ALU, SETC/CLRC and branch
//             consumption, and saves/restores flags through a shadow stack.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ccr_ctrl #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    ccr_ctrl_if.slave   bus
);
    localparam int               IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] c_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    // Flag bit positions inside {C,N,Z}
    localparam int c_Z = 0;
    localparam int c_N = 1;
    localparam int c_C = 2;

    logic [2:0]       r_ccr;
    logic [CNT_W-1:0] r_depth;
    logic             r_ovf_err;
    logic             r_unf_err;
    logic [2:0]       r_stack [DEPTH];

    logic             w_zn_upd;
    logic             w_c_upd;
    logic [2:0]       w_pre_br;
    logic [2:0]       w_nxt;
    logic             w_taken;
    logic [CNT_W-1:0] w_top;

    always_comb begin
        w_zn_upd = bus.ex_valid && (bus.alu_op >= 4'd4) && (bus.alu_op <= 4'd13)
                   && (bus.alu_op != 4'd7);
        w_c_upd  = bus.ex_valid && ((bus.alu_op == 4'd5) || (bus.alu_op == 4'd8) ||
                                    (bus.alu_op == 4'd12) || (bus.alu_op == 4'd13));

        w_pre_br = r_ccr;
        if (w_zn_upd) begin
            w_pre_br[c_Z] = bus.alu_flags[c_Z];
            w_pre_br[c_N] = bus.alu_flags[c_N];
        end
        if (w_c_upd) begin
            w_pre_br[c_C] = bus.alu_flags[c_C];
        end
        // Simultaneous SETC and CLRC cancel out and leave C as-is
        if (bus.ex_valid && bus.setc && !bus.clrc) begin
            w_pre_br[c_C] = 1'b1;
        end else if (bus.ex_valid && bus.clrc && !bus.setc) begin
            w_pre_br[c_C] = 1'b0;
        end

        w_nxt   = w_pre_br;
        w_taken = 1'b0;
        if (bus.br_valid) begin
            case (bus.br_cond)
                2'b00:   w_taken = w_pre_br[c_Z];
                2'b01:   w_taken = w_pre_br[c_N];
                2'b10:   w_taken = w_pre_br[c_C];
                default: w_taken = 1'b1;
            endcase
            // A taken conditional jump consumes the flag it tested
            if (w_taken && (bus.br_cond != 2'b11)) begin
                w_nxt[bus.br_cond] = 1'b0;
            end
        end

        w_top = r_depth - c_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ccr     <= '0;
            r_depth   <= '0;
            r_ovf_err <= 1'b0;
            r_unf_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_stack[i] <= '0;
            end
        end else if (!bus.stall) begin
            if (bus.rti_restore) begin
                if (r_depth != '0) begin
                    r_ccr   <= r_stack[w_top[IDX_W-1:0]];
                    r_depth <= w_top;
                end else begin
                    r_ccr     <= w_nxt;
                    r_unf_err <= 1'b1;
                end
            end else if (bus.int_save) begin
                if (r_depth != c_FULL) begin
                    r_stack[r_depth[IDX_W-1:0]] <= w_nxt;
                    r_depth                     <= r_depth + c_ONE;
                end else begin
                    r_ovf_err <= 1'b1;
                end
                r_ccr <= w_nxt;
            end else begin
                r_ccr <= w_nxt;
            end
        end
    end

    assign bus.ccr      = r_ccr;
    assign bus.br_taken = w_taken;
    assign bus.depth    = r_depth;
    assign bus.ovf_err  = r_ovf_err;
    assign bus.unf_err  = r_unf_err;

endmodule

`default_nettype wire

// File: tb/tb_ccr_ctrl.sv
// ============================================================================
//  Module   : tb_ccr_ctrl
//  Purpose  : Directed self-checking bench for ccr_ctrl with hand-computed
//             expected flag, branch, depth and error values.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ccr_ctrl;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    ccr_ctrl_if #(.CNT_W(3)) bus ();

    ccr_ctrl #(.DEPTH(4), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic ex, input logic [3:0] op, input logic [2:0] fl,
                         input logic sc, input logic cc, input logic bv,
                         input logic [1:0] bc, input logic is, input logic rr);
        bus.ex_valid    = ex;
        bus.alu_op      = op;
        bus.alu_flags   = fl;
        bus.setc        = sc;
        bus.clrc        = cc;
        bus.br_valid    = bv;
        bus.br_cond     = bc;
        bus.int_save    = is;
        bus.rti_restore = rr;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n     = 1'b0;
        bus.stall = 1'b0;
        idle();
        tick();
        tick();

        // Reset state; unconditional jump is the only taken branch with flags clear
        check("rst_ccr",   {5'd0, bus.ccr},   8'h00);
        check("rst_depth", {5'd0, bus.depth}, 8'h00);
        check("rst_ovf",   {7'd0, bus.ovf_err}, 8'h00);
        check("rst_unf",   {7'd0, bus.unf_err}, 8'h00);
        check("rst_br",    {7'd0, bus.br_taken}, 8'h00);
        drive(1'b0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0);
        #1;
        check("rst_jmp", {7'd0, bus.br_taken}, 8'h01);
        idle();
        rst_n = 1'b1;
        tick();

        // T1: ADD writes all flags, MOV writes none
        drive(1'b1, 4'd8, 3'b101, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        tick();
        check("t1_add", {5'd0, bus.ccr}, 8'h05);
        drive(1'b1, 4'd7, 3'b010, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        tick();
        check("t1_mov", {5'd0, bus.ccr}, 8'h05);

        // Clear to 000: logic op zeroes Z/N, CLRC zeroes C
        drive(1'b1, 4'd4, 3'b000, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        tick();
        check("t2_clr", {5'd0, bus.ccr}, 8'h00);

        // T2: DEC sets Z, same-cycle JZ forwards and consumes it
        drive(1'b1, 4'd6, 3'b001, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        #1;
        check("t2_jz_br", {7'd0, bus.br_taken}, 8'h01);
        tick();
        check("t2_jz_ccr", {5'd0, bus.ccr}, 8'h00);
        drive(1'b1, 4'd6, 3'b001, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
        #1;
        check("t2_jn_br", {7'd0, bus.br_taken}, 8'h00);
        tick();
        check("t2_jn_ccr", {5'd0, bus.ccr}, 8'h01);

        // T3: back to 000, then SHL C=1 with SETC&CLRC cancelling
        drive(1'b1, 4'd4, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        tick();
        check("t3_clr", {5'd0, bus.ccr}, 8'h00);
        drive(1'b1, 4'd12, 3'b100, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        tick();
        check("t3_shl", {5'd0, bus.ccr}, 8'h04);
        drive(1'b0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
        #1;
        check("t3_jc_br", {7'd0, bus.br_taken}, 8'h01);
        tick();
        check("t3_jc_ccr", {5'd0, bus.ccr}, 8'h00);
        drive(1'b1, 4'd12, 3'b100, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        tick();
        check("t3_setc", {5'd0, bus.ccr}, 8'h04);
        drive(1'b1, 4'd0, 3'b000, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
        #1;
        check("t3_jmp_br", {7'd0, bus.br_taken}, 8'h01);
        tick();
        check("t3_clrc", {5'd0, bus.ccr}, 8'h00);

        // T4: fill the stack with 001,010,011,100, overflow, drain, underflow
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 4'd8, 3'(i), 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
            tick();
            check($sformatf("t4_push%0d_ccr", i), {5'd0, bus.ccr}, 8'(i));
            check($sformatf("t4_push%0d_dep", i), {5'd0, bus.depth}, 8'(i));
        end
        drive(1'b0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        tick();
        check("t4_ovf",     {7'd0, bus.ovf_err}, 8'h01);
        check("t4_ovf_dep", {5'd0, bus.depth},   8'h04);
        check("t4_ovf_ccr", {5'd0, bus.ccr},     8'h04);
        for (int i = 4; i >= 1; i--) begin
            drive(1'b1, 4'd8, 3'b111, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
            tick();
            check($sformatf("t4_pop%0d_ccr", i), {5'd0, bus.ccr}, 8'(i));
            check($sformatf("t4_pop%0d_dep", i), {5'd0, bus.depth}, 8'(i - 1));
        end
        check("t4_unf_pre", {7'd0, bus.unf_err}, 8'h00);
        drive(1'b0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        tick();
        check("t4_unf",     {7'd0, bus.unf_err}, 8'h01);
        check("t4_unf_dep", {5'd0, bus.depth},   8'h00);
        check("t4_unf_ccr", {5'd0, bus.ccr},     8'h01);

        // T5: stall holds everything; branch still resolves combinationally
        bus.stall = 1'b1;
        drive(1'b1, 4'd8, 3'b111, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0);
        #1;
        check("t5_stall_br", {7'd0, bus.br_taken}, 8'h01);
        tick();
        check("t5_stall_ccr", {5'd0, bus.ccr},   8'h01);
        check("t5_stall_dep", {5'd0, bus.depth}, 8'h00);
        bus.stall    = 1'b0;
        bus.br_valid = 1'b0;
        tick();
        check("t5_go_ccr", {5'd0, bus.ccr},   8'h07);
        check("t5_go_dep", {5'd0, bus.depth}, 8'h01);

        // T6: rebuild depth=1 holding 010, ccr=101, then async reset
        drive(1'b0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        tick();
        check("t6_pop", {5'd0, bus.ccr}, 8'h07);
        drive(1'b1, 4'd8, 3'b010, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        tick();
        drive(1'b1, 4'd8, 3'b101, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        tick();
        check("t6_pre_ccr", {5'd0, bus.ccr},   8'h05);
        check("t6_pre_dep", {5'd0, bus.depth}, 8'h01);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_ccr", {5'd0, bus.ccr},     8'h00);
        check("t6_rst_dep", {5'd0, bus.depth},   8'h00);
        check("t6_rst_ovf", {7'd0, bus.ovf_err}, 8'h00);
        check("t6_rst_unf", {7'd0, bus.unf_err}, 8'h00);
        tick();
        rst_n = 1'b1;
        drive(1'b0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
        tick();
        check("t6_both_unf", {7'd0, bus.unf_err}, 8'h01);
        check("t6_both_ovf", {7'd0, bus.ovf_err}, 8'h00);
        check("t6_both_dep", {5'd0, bus.depth},   8'h00);
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
